mic_airflow_detector: RTL and testbench
=======================================

MIC_AIRFLOW_DETECTOR -- requirements
Module: mic_airflow_detector

Interface
REQ-001 Parameter WINDOW_LOG2, default 11: log2 of samples per measurement window (range 1..16).
REQ-002 Parameter TH1, default 32'd2000000: peak threshold for airflow level 1.
REQ-003 Parameter TH2, default 32'd8000000: peak threshold for airflow level 2.
REQ-004 Parameter TH3, default 32'd20000000: peak threshold for airflow level 3.
REQ-005 Parameter HYST, default 32'd500000: hysteresis margin applied on level decrease.
REQ-006 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-007 CLOCK_50  input  1  system clock; all state on its rising edge.
REQ-008 resetn  input  1  asynchronous active-low reset.
REQ-009 audio_in_available  input  1  Audio_Controller input FIFO holds at least one sample pair.
REQ-010 left_channel_audio_in  input  32  signed left sample; valid while audio_in_available is high.
REQ-011 right_channel_audio_in  input  32  signed right sample; valid while audio_in_available is high.
REQ-012 read_audio_in  output  1  one-cycle pop strobe to Audio_Controller.
REQ-013 airflow  output  2  classified breath level; drop-in replacement for the SW[1:0] airflow code.
REQ-014 airflow_valid  output  1  one-cycle pulse when airflow is re-evaluated.
REQ-015 peak  output  32  unsigned peak magnitude of the last completed window.

Function
REQ-016 The FSM SHALL have exactly three states: WAIT, ACCUM, UPDATE.
REQ-017 In WAIT with audio_in_available=1, read_audio_in SHALL be 1 for that cycle only, both samples SHALL be registered in the same cycle, and the next state SHALL be ACCUM.
REQ-018 In WAIT with audio_in_available=0, read_audio_in SHALL be 0 and the state SHALL hold.
REQ-019 read_audio_in SHALL never be high in ACCUM or UPDATE; the maximum read rate is one pop per 2 cycles.
REQ-020 ACCUM SHALL compute the magnitude of each registered sample as two's-complement absolute value; 32'h80000000 SHALL saturate to 32'h7FFFFFFF.
REQ-021 ACCUM SHALL update the running maximum to the greater of itself and the sample magnitude, and increment a WINDOW_LOG2-bit sample counter.
REQ-022 When the counter wraps to 0, i.e. 2^WINDOW_LOG2 samples are accumulated, ACCUM SHALL go to UPDATE; otherwise it SHALL return to WAIT.
REQ-023 UPDATE SHALL last one cycle: load peak with the running maximum (including the final sample), clear the running maximum to 0, pulse airflow_valid, return to WAIT.
REQ-024 Raw level SHALL be 0 if m<TH1, 1 if TH1<=m<TH2, 2 if TH2<=m<TH3, 3 if m>=TH3, where m is the window maximum (unsigned compare).
REQ-025 If raw level >= current airflow, airflow SHALL take the raw level.
REQ-026 If raw level < current airflow, airflow SHALL drop to the highest level L whose threshold satisfies m >= TH(L)-HYST (TH(0)-HYST treated as 0), limited to current airflow.
REQ-027 airflow, peak and airflow_valid SHALL change only in UPDATE; between windows they SHALL hold.
REQ-028 audio_in_available deasserting mid-window SHALL stall accumulation without discarding the partial window.

Reset
REQ-029 resetn=0 SHALL immediately force state=WAIT, read_audio_in=0, airflow=2'b00, airflow_valid=0, peak=0, running maximum=0, counter=0.
REQ-030 Reset asserted mid-window SHALL discard the partial window; the first airflow_valid after release SHALL follow exactly 2^WINDOW_LOG2 new pops.

Configuration
REQ-031 Macro MIC_AIRFLOW_STEREO_EN defined: the per-sample magnitude SHALL be the maximum of the left and right magnitudes.
REQ-032 Macro MIC_AIRFLOW_STEREO_EN undefined: only the left channel SHALL be used, right_channel_audio_in SHALL be ignored, and the pop handshake SHALL be unchanged.

Structure
REQ-033 Package mic_airflow_pkg SHALL hold the FSM state encoding, the airflow level constants (AIR_NONE=0..AIR_HIGH=3) and the default TH1/TH2/TH3/HYST values.
REQ-034 The saturating absolute value SHALL be a sub-module abs_sat32 (32-bit signed in, 32-bit unsigned out, combinational), instantiated once per channel used.

Verification (WINDOW_LOG2=2, default thresholds)
REQ-035 audio_in_available held 1; 4 samples of +3000000 -> exactly 4 single-cycle read_audio_in pulses spaced 2 cycles apart, then airflow_valid pulse with airflow=1, peak=3000000.
REQ-036 Samples {0, -25000000, 100, 5} -> airflow=3, peak=25000000.
REQ-037 Starting from airflow=3: window peak 19700000 -> airflow stays 3; next window peak 19400000 -> airflow=2.
REQ-038 Left=32'h80000000 sample in a window -> peak=32'h7FFFFFFF, airflow=3.
REQ-039 audio_in_available toggled 1/0 every 3 cycles -> no pop while low; airflow_valid only after the 4th pop.
REQ-040 resetn pulsed low after 2 pops -> outputs zero immediately; the next airflow_valid follows 4 fresh pops; with MIC_AIRFLOW_STEREO_EN, left=0 and right=9000000 -> airflow=2.

Source files
------------

// File: rtl/mic_airflow_pkg.sv
// Shared types and constants for the microphone airflow detector:
// FSM encoding, airflow level codes, default thresholds and level helpers.
package mic_airflow_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [1:0] AIR_NONE = 2'd0;
  localparam logic [1:0] AIR_LOW  = 2'd1;
  localparam logic [1:0] AIR_MID  = 2'd2;
  localparam logic [1:0] AIR_HIGH = 2'd3;

  localparam logic [31:0] TH1_DEF  = 32'd2000000;
  localparam logic [31:0] TH2_DEF  = 32'd8000000;
  localparam logic [31:0] TH3_DEF  = 32'd20000000;
  localparam logic [31:0] HYST_DEF = 32'd500000;

  // Release point for a level; clamps at zero so small thresholds never wrap.
  function automatic logic [31:0] hyst_floor(input logic [31:0] th, input logic [31:0] hyst);
    return (th > hyst) ? (th - hyst) : 32'd0;
  endfunction

  function automatic logic [1:0] raw_level(input logic [31:0] m, input logic [31:0] th1,
                                           input logic [31:0] th2, input logic [31:0] th3);
    logic [1:0] lvl;
    if (m >= th3)      lvl = AIR_HIGH;
    else if (m >= th2) lvl = AIR_MID;
    else if (m >= th1) lvl = AIR_LOW;
    else               lvl = AIR_NONE;
    return lvl;
  endfunction

  // Rising levels follow the raw level directly; falling levels only drop
  // as far as the hysteresis band allows, never above the current level.
  function automatic logic [1:0] next_level(input logic [1:0] cur, input logic [31:0] m,
                                            input logic [31:0] th1, input logic [31:0] th2,
                                            input logic [31:0] th3, input logic [31:0] hyst);
    logic [1:0] raw;
    logic [1:0] lvl;
    raw = raw_level(m, th1, th2, th3);
    if (raw >= cur)                                            lvl = raw;
    else if (cur == AIR_HIGH && m >= hyst_floor(th3, hyst))    lvl = AIR_HIGH;
    else if (cur >= AIR_MID && m >= hyst_floor(th2, hyst))     lvl = AIR_MID;
    else if (m >= hyst_floor(th1, hyst))                       lvl = AIR_LOW;
    else                                                       lvl = AIR_NONE;
    return lvl;
  endfunction

endpackage

// File: rtl/mic_airflow_detector_if.sv
// Audio_Controller input-FIFO handshake: sample pair plus one-cycle pop strobe.
interface mic_airflow_detector_if;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;

  modport master (
    output audio_in_available,
    output left_channel_audio_in,
    output right_channel_audio_in,
    input  read_audio_in
  );

  modport slave (
    input  audio_in_available,
    input  left_channel_audio_in,
    input  right_channel_audio_in,
    output read_audio_in
  );
endinterface

// File: rtl/mic_airflow_detector_abs_sat32.sv
// Combinational two's-complement magnitude; the most negative value saturates
// to 32'h7FFFFFFF so the result always fits the signed positive range.
module abs_sat32 (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  always_comb begin
    if (!din[31])                 dout = din;
    else if (din == 32'h80000000) dout = 32'h7FFFFFFF;
    else                          dout = (~din) + 32'd1;
  end
endmodule

// File: rtl/mic_airflow_detector.sv
// Windowed peak detector that classifies breath airflow into four levels.
// Define MIC_AIRFLOW_STEREO_EN to take the per-sample max over both channels.
//
// state  | meaning
// WAIT   | idle until a sample pair is available; pop and capture it
// ACCUM  | fold captured sample magnitude into the running max, count it
// UPDATE | window complete: publish peak, reclassify airflow, clear max
module mic_airflow_detector
  import mic_airflow_pkg::*;
#(
  parameter int unsigned  WINDOW_LOG2 = 11,
  parameter logic [31:0]  TH1         = TH1_DEF,
  parameter logic [31:0]  TH2         = TH2_DEF,
  parameter logic [31:0]  TH3         = TH3_DEF,
  parameter logic [31:0]  HYST        = HYST_DEF
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  mic_airflow_detector_if.slave  aud,
  output logic [1:0]             airflow,
  output logic                   airflow_valid,
  output logic [31:0]            peak
);

  localparam logic [WINDOW_LOG2-1:0] CNT_ONE = WINDOW_LOG2'(1);

  state_t                 state_q, state_d;
  logic [31:0]            left_q, left_d;
  logic [31:0]            run_max_q, run_max_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [31:0]            peak_q, peak_d;
  logic [1:0]             airflow_q, airflow_d;
  logic                   valid_q, valid_d;
  logic                   pop;
  logic [31:0]            mag_l;
  logic [31:0]            mag;

  abs_sat32 u_abs_left (.din(left_q), .dout(mag_l));

`ifdef MIC_AIRFLOW_STEREO_EN
  logic [31:0] right_q, right_d;
  logic [31:0] mag_r;

  abs_sat32 u_abs_right (.din(right_q), .dout(mag_r));

  assign mag = (mag_r > mag_l) ? mag_r : mag_l;

  always_comb begin
    right_d = right_q;
    if (state_q == WAIT && aud.audio_in_available) right_d = aud.right_channel_audio_in;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) right_q <= '0;
    else         right_q <= right_d;
  end
`else
  assign mag = mag_l;
`endif

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    run_max_d = run_max_q;
    cnt_d     = cnt_q;
    peak_d    = peak_q;
    airflow_d = airflow_q;
    valid_d   = 1'b0;
    pop       = 1'b0;
    case (state_q)
      WAIT: begin
        if (aud.audio_in_available) begin
          pop     = 1'b1;
          left_d  = aud.left_channel_audio_in;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (mag > run_max_q) run_max_d = mag;
        cnt_d   = cnt_q + CNT_ONE;
        state_d = (cnt_d == '0) ? UPDATE : WAIT;
      end
      UPDATE: begin
        peak_d    = run_max_q;
        run_max_d = '0;
        valid_d   = 1'b1;
        airflow_d = next_level(airflow_q, run_max_q, TH1, TH2, TH3, HYST);
        state_d   = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= WAIT;
      left_q    <= '0;
      run_max_q <= '0;
      cnt_q     <= '0;
      peak_q    <= '0;
      airflow_q <= AIR_NONE;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      left_q    <= left_d;
      run_max_q <= run_max_d;
      cnt_q     <= cnt_d;
      peak_q    <= peak_d;
      airflow_q <= airflow_d;
      valid_q   <= valid_d;
    end
  end

  // The pop must coincide with the capture cycle, so it is decoded from the
  // state rather than registered; gating with resetn keeps it low in reset.
  assign aud.read_audio_in = pop & resetn;
  assign airflow           = airflow_q;
  assign airflow_valid     = valid_q;
  assign peak              = peak_q;

endmodule

// File: tb/tb_mic_airflow_detector.sv
// Directed bench for mic_airflow_detector with WINDOW_LOG2=2 and default thresholds.
module tb_mic_airflow_detector;

  logic        clk;
  logic        rst_n;
  logic [1:0]  airflow;
  logic        airflow_valid;
  logic [31:0] peak;

  mic_airflow_detector_if aif ();

  mic_airflow_detector #(.WINDOW_LOG2(2)) dut (
    .CLOCK_50      (clk),
    .resetn        (rst_n),
    .aud           (aif.slave),
    .airflow       (airflow),
    .airflow_valid (airflow_valid),
    .peak          (peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int pop_cnt   = 0;
  int valid_cnt = 0;
  int dbl_pop   = 0;
  int pop_noav  = 0;
  int cyc       = 0;
  int pop_times[$];
  logic rd_prev = 1'b0;

  // Sample just before each rising edge, when the handshake is settled.
  always @(negedge clk) begin
    #4;
    cyc++;
    if (aif.read_audio_in) begin
      pop_cnt++;
      pop_times.push_back(cyc);
      if (rd_prev) dbl_pop++;
      if (!aif.audio_in_available) pop_noav++;
    end
    if (airflow_valid) valid_cnt++;
    rd_prev = aif.read_audio_in;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h (%0d) want 0x%08h (%0d)", nm, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    int p0;
    int t;
    p0 = pop_cnt;
    t  = 0;
    aif.audio_in_available     = 1'b1;
    aif.left_channel_audio_in  = l;
    aif.right_channel_audio_in = r;
    while (pop_cnt == p0 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    aif.audio_in_available = 1'b0;
    if (pop_cnt == p0) check("pop_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (!airflow_valid && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    check({nm, "_valid"}, {31'd0, airflow_valid}, 32'd1);
  endtask

  typedef struct packed {
    logic [3:0][31:0] l;
    logic [31:0]      r;
    logic [1:0]       af;
    logic [31:0]      pk;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] l0, input logic [31:0] l1,
                              input logic [31:0] l2, input logic [31:0] l3,
                              input logic [31:0] r, input logic [1:0] af,
                              input logic [31:0] pk);
    vec_t v;
    v.l[0] = l0; v.l[1] = l1; v.l[2] = l2; v.l[3] = l3;
    v.r = r; v.af = af; v.pk = pk;
    return v;
  endfunction

  localparam int NV = 14;
  vec_t tbl[NV];

  initial begin
    int mark;
    int vmark;
    bit got;

    // Rows run back to back, so each expected level depends on the previous row.
    tbl[0]  = mk(32'd3000000, 32'd3000000, 32'd3000000, 32'd3000000, 32'd0, 2'd1, 32'd3000000);
    tbl[1]  = mk(32'd0, -32'sd25000000, 32'd100, 32'd5, 32'd0, 2'd3, 32'd25000000);
    tbl[2]  = mk(32'd19700000, 32'd0, 32'd0, 32'd0, 32'd0, 2'd3, 32'd19700000);
    tbl[3]  = mk(32'd19400000, 32'd0, 32'd0, 32'd0, 32'd0, 2'd2, 32'd19400000);
    tbl[4]  = mk(32'h80000000, 32'd1, 32'd2, 32'd3, 32'd0, 2'd3, 32'h7FFFFFFF);
    tbl[5]  = mk(32'd1999999, 32'd0, 32'd0, 32'd0, 32'd0, 2'd1, 32'd1999999);
    tbl[6]  = mk(32'd1500000, 32'd0, 32'd0, 32'd0, 32'd0, 2'd1, 32'd1500000);
    tbl[7]  = mk(32'd1499999, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 32'd1499999);
    tbl[8]  = mk(32'd0, 32'd0, 32'd0, 32'd2000000, 32'd0, 2'd1, 32'd2000000);
    tbl[9]  = mk(32'd7999999, -32'sd8000000, 32'd0, 32'd0, 32'd0, 2'd2, 32'd8000000);
    tbl[10] = mk(32'd0, -32'sd20000000, 32'd0, 32'd0, 32'd0, 2'd3, 32'd20000000);
    tbl[11] = mk(32'd7500000, 32'd0, 32'd0, 32'd0, 32'd0, 2'd2, 32'd7500000);
    tbl[12] = mk(32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 32'd1);
`ifdef MIC_AIRFLOW_STEREO_EN
    tbl[13] = mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd9000000, 2'd2, 32'd9000000);
`else
    tbl[13] = mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd9000000, 2'd0, 32'd0);
`endif

    rst_n = 1'b0;
    aif.audio_in_available     = 1'b0;
    aif.left_channel_audio_in  = '0;
    aif.right_channel_audio_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_airflow", {30'd0, airflow}, 32'd0);
    check("rst_peak", peak, 32'd0);
    check("rst_valid", {31'd0, airflow_valid}, 32'd0);
    aif.audio_in_available = 1'b1;
    #1;
    check("rst_read_gated", {31'd0, aif.read_audio_in}, 32'd0);
    aif.audio_in_available = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Available held high: four pops two cycles apart, then one window result.
    mark = pop_cnt;
    pop_times.delete();
    aif.audio_in_available    = 1'b1;
    aif.left_channel_audio_in = 32'd3000000;
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk); #1;
      if (airflow_valid) begin
        got = 1;
        aif.audio_in_available = 1'b0;
      end
    end
    check("held_valid", {31'd0, got}, 32'd1);
    check("held_pops", pop_cnt - mark, 32'd4);
    if (pop_times.size() >= 4) check("held_span", pop_times[3] - pop_times[0], 32'd6);
    else                       check("held_span_count", pop_times.size(), 32'd4);
    check("held_airflow", {30'd0, airflow}, 32'd1);
    check("held_peak", peak, 32'd3000000);
    @(negedge clk); #1;
    check("held_valid_width", {31'd0, airflow_valid}, 32'd0);
    check("held_peak_hold", peak, 32'd3000000);

    for (int i = 0; i < NV; i++) begin
      mark = pop_cnt;
      for (int s = 0; s < 4; s++) begin
        push(tbl[i].l[s], tbl[i].r);
        if (s < 3) check($sformatf("v%0d_early_valid", i), {31'd0, airflow_valid}, 32'd0);
      end
      wait_valid($sformatf("v%0d", i));
      check($sformatf("v%0d_pops", i), pop_cnt - mark, 32'd4);
      check($sformatf("v%0d_airflow", i), {30'd0, airflow}, {30'd0, tbl[i].af});
      check($sformatf("v%0d_peak", i), peak, tbl[i].pk);
      @(negedge clk); #1;
      check($sformatf("v%0d_valid_width", i), {31'd0, airflow_valid}, 32'd0);
    end

    // Availability toggling every three cycles stalls but keeps the window.
    mark  = pop_cnt;
    vmark = valid_cnt;
    aif.left_channel_audio_in  = 32'd9000000;
    aif.right_channel_audio_in = 32'd0;
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      aif.audio_in_available = ((c / 3) % 2 == 0);
      @(negedge clk); #1;
      if (airflow_valid) begin
        got = 1;
        aif.audio_in_available = 1'b0;
      end
    end
    check("tog_valid", {31'd0, got}, 32'd1);
    check("tog_pops", pop_cnt - mark, 32'd4);
    check("tog_no_early_valid", valid_cnt - vmark, 32'd0);
    check("tog_airflow", {30'd0, airflow}, 32'd2);
    check("tog_peak", peak, 32'd9000000);
    @(negedge clk); #1;

    // Reset mid-window: outputs clear at once and the partial window is lost.
    push(32'd25000000, 32'd0);
    push(32'd25000000, 32'd0);
    aif.audio_in_available    = 1'b1;
    aif.left_channel_audio_in = 32'd25000000;
    rst_n = 1'b0;
    #1;
    check("mid_rst_airflow", {30'd0, airflow}, 32'd0);
    check("mid_rst_peak", peak, 32'd0);
    check("mid_rst_valid", {31'd0, airflow_valid}, 32'd0);
    check("mid_rst_read", {31'd0, aif.read_audio_in}, 32'd0);
    @(negedge clk); #1;
    check("mid_rst_read_hold", {31'd0, aif.read_audio_in}, 32'd0);
    aif.audio_in_available = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    mark  = pop_cnt;
    vmark = valid_cnt;
    for (int s = 0; s < 4; s++) push(32'd1000000, 32'd9000000);
    wait_valid("post_rst");
    check("post_rst_pops", pop_cnt - mark, 32'd4);
    check("post_rst_no_early_valid", valid_cnt - vmark, 32'd0);
`ifdef MIC_AIRFLOW_STEREO_EN
    check("post_rst_airflow", {30'd0, airflow}, 32'd2);
    check("post_rst_peak", peak, 32'd9000000);
`else
    check("post_rst_airflow", {30'd0, airflow}, 32'd0);
    check("post_rst_peak", peak, 32'd1000000);
`endif
    @(negedge clk); #1;

    check("no_back_to_back_pops", dbl_pop, 32'd0);
    check("no_pop_without_avail", pop_noav, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
